// File: rtl/sel_decoder_pkg.sv
// Shared definitions for the select decoder: parameter legality limits and a
// helper that tells whether a WIDTH/OUTS pairing can be built.
package sel_decoder_pkg;

  localparam int MAX_WIDTH = 8;

  // A configuration is buildable when the select fits the supported width and
  // the populated outputs fit within the binary range of the select.
  function automatic bit isLegalConfig(input int width, input int outs);
    bit legal;
    legal = 1'b1;
    if (width < 1 || width > MAX_WIDTH) legal = 1'b0;
    else if (outs < 1 || outs > (1 << width)) legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/sel_decoder_onehot_comb.sv
// Purely combinational binary-to-one-hot conversion. Produces one line per
// populated output plus a flag saying whether the select lands on one of them.
module sel_decoder_onehot_comb
  import sel_decoder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int OUTS  = 1 << WIDTH
) (
  input  logic [WIDTH-1:0] sel_i,
  output logic [OUTS-1:0]  onehot_o,
  output logic             in_range_o
);

  // OUTS never exceeds 2^WIDTH, so one extra bit is enough to hold it and
  // compare against a zero-extended select without losing the top value.
  localparam logic [WIDTH:0] OUTS_W = (WIDTH + 1)'(OUTS);

  // Raise only the line whose index equals the select; an out-of-range select
  // matches no populated index and leaves every line low.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < OUTS; i++) begin
      onehot_o[i] = (sel_i == WIDTH'(i));
    end
  end

  // The select is usable only when it addresses a populated output.
  always_comb begin
    in_range_o = ({1'b0, sel_i} < OUTS_W);
  end

endmodule

// File: rtl/sel_decoder.sv
// Registered binary-to-one-hot decoder with enable gating, a valid flag and an
// out-of-range flag. Every output comes straight from a flop.
module sel_decoder
  import sel_decoder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int OUTS  = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sel,
  output logic [OUTS-1:0]  out,
  output logic             out_valid,
  output logic             range_err
);

  // Refuse to elaborate a configuration whose outputs cannot all be addressed
  // or whose select is wider than supported.
  if (!isLegalConfig(WIDTH, OUTS)) begin : g_param_check
    $fatal(1, "sel_decoder: illegal configuration WIDTH=%0d OUTS=%0d", WIDTH, OUTS);
  end

  logic [OUTS-1:0] onehot;
  logic            inRange;

  logic [OUTS-1:0] out_d, out_q;
  logic            valid_d, valid_q;
  logic            err_d, err_q;

  sel_decoder_onehot_comb #(
    .WIDTH (WIDTH),
    .OUTS  (OUTS)
  ) u_onehot (
    .sel_i      (sel),
    .onehot_o   (onehot),
    .in_range_o (inRange)
  );

  // Gate the decode with the enable; a disabled cycle clears everything rather
  // than holding the previous lane, and out_valid tracks a set lane exactly.
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      out_d   = onehot;
      valid_d = inRange;
      err_d   = !inRange;
    end
  end

  // Output registers with synchronous reset that overrides enable and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_sel_decoder.sv
// Directed bench for sel_decoder: a fully populated 5-bit instance and a
// partially populated 3-bit/5-output instance driven side by side.
module tb_sel_decoder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  selA;
  logic [2:0]  selB;
  logic [31:0] outA;
  logic        validA, errA;
  logic [4:0]  outB;
  logic        validB, errB;

  int assertCount;
  int failCount;

  sel_decoder #(.WIDTH(5), .OUTS(32)) dutFull (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sel       (selA),
    .out       (outA),
    .out_valid (validA),
    .range_err (errA)
  );

  sel_decoder #(.WIDTH(3), .OUTS(5)) dutPartial (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sel       (selB),
    .out       (outB),
    .out_valid (validB),
    .range_err (errB)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then wait past the next rising edge so
  // the registered outputs are sampled away from the clock.
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [4:0] sa, input logic [2:0] sb);
    @(negedge clk);
    rst  = r;
    en   = e;
    selA = sa;
    selB = sb;
    @(posedge clk);
    #1;
  endtask

  // Compare both instances against expected values and the output invariants.
  task automatic checkOutput(input string tag,
                             input logic [31:0] expOutA, input logic expValidA, input logic expErrA,
                             input logic [4:0]  expOutB, input logic expValidB, input logic expErrB);
    assertCount++;
    assert (outA === expOutA) else begin
      failCount++;
      $error("[TB] FAIL %s outA observed=%h expected=%h", tag, outA, expOutA);
    end
    assertCount++;
    assert (validA === expValidA) else begin
      failCount++;
      $error("[TB] FAIL %s validA observed=%b expected=%b", tag, validA, expValidA);
    end
    assertCount++;
    assert (errA === expErrA) else begin
      failCount++;
      $error("[TB] FAIL %s errA observed=%b expected=%b", tag, errA, expErrA);
    end
    assertCount++;
    assert (outB === expOutB) else begin
      failCount++;
      $error("[TB] FAIL %s outB observed=%b expected=%b", tag, outB, expOutB);
    end
    assertCount++;
    assert (validB === expValidB) else begin
      failCount++;
      $error("[TB] FAIL %s validB observed=%b expected=%b", tag, validB, expValidB);
    end
    assertCount++;
    assert (errB === expErrB) else begin
      failCount++;
      $error("[TB] FAIL %s errB observed=%b expected=%b", tag, errB, expErrB);
    end
    assertCount++;
    assert ($onehot0(outA) && (validA === (|outA)) && !(validA && errA)) else begin
      failCount++;
      $error("[TB] FAIL %s invariantA observed out=%h valid=%b err=%b expected onehot0 with valid==|out", tag, outA, validA, errA);
    end
    assertCount++;
    assert ($onehot0(outB) && (validB === (|outB)) && !(validB && errB)) else begin
      failCount++;
      $error("[TB] FAIL %s invariantB observed out=%b valid=%b err=%b expected onehot0 with valid==|out", tag, outB, validB, errB);
    end
  endtask

  // Directed sequence covering reset, sweep, gating, partial population,
  // mid-stream reset and back-to-back select changes.
  initial begin
    assertCount = 0;
    failCount   = 0;
    rst  = 1'b1;
    en   = 1'b0;
    selA = '0;
    selB = '0;

    // Reset held for two cycles while en/sel request a decode.
    applyStimulus(1'b1, 1'b1, 5'd3, 3'd3);
    checkOutput("reset1", 32'h0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 3'd3);
    checkOutput("reset2", 32'h0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);

    // First decode after release.
    applyStimulus(1'b0, 1'b1, 5'd3, 3'd3);
    checkOutput("release", 32'h0000_0008, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0);

    // Sweep every select; the partial instance sees sel mod 8.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] eA;
      logic [4:0]  eB;
      int          sB;
      sB = i % 8;
      eA = 32'h1 << i;
      eB = (sB < 5) ? (5'b00001 << sB) : 5'b00000;
      applyStimulus(1'b0, 1'b1, 5'(i), 3'(sB));
      checkOutput($sformatf("sweep%0d", i), eA, 1'b1, 1'b0, eB, (sB < 5), (sB >= 5));
    end

    // Enable gating with sel=7 held: partial instance is out of range.
    applyStimulus(1'b0, 1'b1, 5'd7, 3'd7);
    checkOutput("gateOn1", 32'h0000_0080, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd7, 3'd7);
    checkOutput("gateOff", 32'h0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd7, 3'd7);
    checkOutput("gateOn2", 32'h0000_0080, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1);

    // Partial population boundaries.
    applyStimulus(1'b0, 1'b1, 5'd31, 3'd4);
    checkOutput("partMsb", 32'h8000_0000, 1'b1, 1'b0, 5'b10000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd0, 3'd5);
    checkOutput("partSel5", 32'h0000_0001, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd1, 3'd6);
    checkOutput("partSel6", 32'h0000_0002, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd2, 3'd7);
    checkOutput("partSel7", 32'h0000_0004, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd2, 3'd6);
    checkOutput("partDisabled", 32'h0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Reset in the middle of a sel=9 stream (partial sees 1).
    applyStimulus(1'b0, 1'b1, 5'd9, 3'd1);
    checkOutput("stream9a", 32'h0000_0200, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd9, 3'd1);
    checkOutput("midReset", 32'h0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd9, 3'd1);
    checkOutput("stream9b", 32'h0000_0200, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0);

    // Back-to-back select change 2 -> 17 (partial sees 2 -> 1).
    applyStimulus(1'b0, 1'b1, 5'd2, 3'd2);
    checkOutput("step2", 32'h0000_0004, 1'b1, 1'b0, 5'b00100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd17, 3'd1);
    checkOutput("step17", 32'h0002_0000, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
